// File: rtl/sram_emulator_model.sv
// Cycle-based model of the board's 256K x 16 asynchronous SRAM: byte-lane writes,
// a registered read path, and a full clear while Resetn is low.
module sram_emulator_model #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clock_50,
  input  logic                  Resetn,
  inout  wire  [DATA_WIDTH-1:0] SRAM_data_io,
  input  logic [ADDR_WIDTH-1:0] SRAM_address,
  input  logic                  SRAM_UB_N,
  input  logic                  SRAM_LB_N,
  input  logic                  SRAM_WE_N,
  input  logic                  SRAM_CE_N,
  input  logic                  SRAM_OE_N
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH != 16) begin : g_bad_width
    $error("sram_emulator_model: DATA_WIDTH must be 16");
  end

  logic [DATA_WIDTH-1:0] SRAM_data [0:DEPTH-1];

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic                  ctrl_unknown;
  logic                  wr_en;
  logic                  rd_en;
  logic                  bus_drive;
  integer                read_count;
  integer                write_count;

  // Unknown controls (or an unknown address on a selected chip) suppress the access.
  assign ctrl_unknown = $isunknown({SRAM_CE_N, SRAM_WE_N}) ||
                        (!SRAM_CE_N && $isunknown(SRAM_address));
  assign wr_en        = !ctrl_unknown && !SRAM_CE_N && !SRAM_WE_N;
  assign rd_en        = !ctrl_unknown && !SRAM_CE_N &&  SRAM_WE_N;
  assign lane_mask    = {{8{~SRAM_UB_N}}, {8{~SRAM_LB_N}}};

  // Write wins over OE_N, so the model never drives while WE_N is low.
  assign bus_drive    = Resetn && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_data_io = bus_drive ? rd_data_q : {DATA_WIDTH{1'bz}};

  always_comb begin
    rd_data_d = rd_data_q;
    if (ctrl_unknown) begin
      rd_data_d = {DATA_WIDTH{1'bx}};
    end else if (rd_en) begin
      rd_data_d = SRAM_data[SRAM_address] & lane_mask;
    end
  end

  // Plain always: the array is also written hierarchically by the bench for preloads.
  always @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        SRAM_data[i] <= '0;
      end
    end else if (wr_en) begin
      if (!SRAM_UB_N) SRAM_data[SRAM_address][15:8] <= SRAM_data_io[15:8];
      if (!SRAM_LB_N) SRAM_data[SRAM_address][7:0]  <= SRAM_data_io[7:0];
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      rd_data_q   <= '0;
      read_count  <= 0;
      write_count <= 0;
    end else begin
      rd_data_q <= rd_data_d;
      if (ctrl_unknown) begin
        $error("sram_emulator_model: X/Z on control or address at time %0t", $time);
      end
      if (wr_en) begin
        write_count <= write_count + 1;
        if (!SRAM_OE_N) begin
          $warning("sram_emulator_model: WE_N and OE_N both low, addr %h at time %0t",
                   SRAM_address, $time);
        end
      end
      if (rd_en) begin
        read_count <= read_count + 1;
      end
    end
  end

endmodule

// File: tb/tb_sram_emulator_model.sv
// Bench for sram_emulator_model: a vector table for single-cycle accesses plus
// hand sequences for reset, burst reads and write/output-enable contention.
module tb_sram_emulator_model;

  logic        Clock_50 = 1'b0;
  logic        Resetn;
  logic [17:0] addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic        tb_drv;
  logic [15:0] tb_wdata;
  tri1  [15:0] SRAM_data_io;   // undriven bus reads back as 16'hFFFF

  assign SRAM_data_io = tb_drv ? tb_wdata : 16'bz;

  always #10 Clock_50 = ~Clock_50;

  sram_emulator_model #(.ADDR_WIDTH(18), .DATA_WIDTH(16)) dut (
    .Clock_50    (Clock_50),
    .Resetn      (Resetn),
    .SRAM_data_io(SRAM_data_io),
    .SRAM_address(addr),
    .SRAM_UB_N   (ub_n),
    .SRAM_LB_N   (lb_n),
    .SRAM_WE_N   (we_n),
    .SRAM_CE_N   (ce_n),
    .SRAM_OE_N   (oe_n)
  );

  typedef struct {
    string       name;
    logic        ce_n, we_n, oe_n, ub_n, lb_n;
    logic [17:0] addr;
    logic        drv;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] exp_bus;
  } vec_t;

  localparam logic [15:0] BUS_Z = 16'hFFFF;

  logic [15:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  vec_t        vecs[15];
  int          rc0, wc0;

  function automatic vec_t mk(string n, logic ce, logic we, logic oe, logic ub, logic lb,
                              logic [17:0] a, logic d, logic [15:0] wd,
                              logic c, logic [15:0] e);
    vec_t v;
    v.name = n; v.ce_n = ce; v.we_n = we; v.oe_n = oe; v.ub_n = ub; v.lb_n = lb;
    v.addr = a; v.drv = d; v.wdata = wd; v.chk = c; v.exp_bus = e;
    return v;
  endfunction

  task automatic check16(string n, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic check_int(string n, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic set_idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
    addr = '0; tb_drv = 1'b0; tb_wdata = '0;
  endtask

  // Called at a falling edge: drive, cross one rising edge, sample at the next falling edge.
  task automatic apply(vec_t v);
    ce_n = v.ce_n; we_n = v.we_n; oe_n = v.oe_n; ub_n = v.ub_n; lb_n = v.lb_n;
    addr = v.addr; tb_drv = v.drv; tb_wdata = v.wdata;
    if (v.chk) begin
      exp_q.push_back(v.exp_bus);
      name_q.push_back(v.name);
    end
    @(posedge Clock_50);
    @(negedge Clock_50);
    if (v.chk) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: scoreboard empty", v.name);
      end else begin
        check16(name_q.pop_front(), SRAM_data_io, exp_q.pop_front());
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge Clock_50);
    Resetn = 1'b0;
    @(posedge Clock_50);
    @(negedge Clock_50);
    set_idle();
    Resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0;
    set_idle();
    repeat (2) @(negedge Clock_50);
    Resetn = 1'b1;
    @(negedge Clock_50);

    // Reset clears a preloaded word and discards an in-flight write.
    dut.SRAM_data[5] <= 16'hABCD;
    @(posedge Clock_50);
    @(negedge Clock_50);
    check16("preload5_persists", dut.SRAM_data[5], 16'hABCD);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 18'h00011;
    tb_drv = 1'b1; tb_wdata = 16'h4242;
    #5;
    Resetn = 1'b0;
    #5;
    check16("reset_clears5", dut.SRAM_data[5], 16'h0000);
    tb_drv = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = 18'd5;
    #1;
    check16("reset_bus_z", SRAM_data_io, BUS_Z);
    @(posedge Clock_50);
    @(negedge Clock_50);
    set_idle();
    Resetn = 1'b1;
    check16("reset_drops_write", dut.SRAM_data[18'h00011], 16'h0000);
    check_int("reset_read_count", dut.read_count, 0);
    check_int("reset_write_count", dut.write_count, 0);
    apply(mk("read_after_reset", 0, 1, 0, 0, 0, 18'd5, 0, 16'h0, 1, 16'h0000));

    // Table-driven single-cycle accesses.
    vecs[0]  = mk("wr_0x10",      0, 0, 1, 0, 0, 18'h00010, 1, 16'h1234, 0, 16'h0);
    vecs[1]  = mk("rd_0x10",      0, 1, 0, 0, 0, 18'h00010, 0, 16'h0000, 1, 16'h1234);
    vecs[2]  = mk("wr7_low_lane", 0, 0, 1, 1, 0, 18'd7,     1, 16'h00AA, 0, 16'h0);
    vecs[3]  = mk("rd7_ub_only",  0, 1, 0, 0, 1, 18'd7,     0, 16'h0000, 1, 16'hFF00);
    vecs[4]  = mk("rd7_full",     0, 1, 0, 0, 0, 18'd7,     0, 16'h0000, 1, 16'hFFAA);
    vecs[5]  = mk("wr9_ce_off",   1, 0, 1, 0, 0, 18'd9,     1, 16'h5555, 0, 16'h0);
    vecs[6]  = mk("bus_z_ce_off", 1, 1, 0, 0, 0, 18'd9,     0, 16'h0000, 1, BUS_Z);
    vecs[7]  = mk("raw_wr_0x20",  0, 0, 1, 0, 0, 18'h00020, 1, 16'hBEEF, 0, 16'h0);
    vecs[8]  = mk("raw_rd_0x20",  0, 1, 0, 0, 0, 18'h00020, 0, 16'h0000, 1, 16'hBEEF);
    vecs[9]  = mk("wr_max_addr",  0, 0, 1, 0, 0, 18'h3FFFF, 1, 16'hA5A5, 0, 16'h0);
    vecs[10] = mk("rd_max_addr",  0, 1, 0, 0, 0, 18'h3FFFF, 0, 16'h0000, 1, 16'hA5A5);
    vecs[11] = mk("wr_no_lanes",  0, 0, 1, 1, 1, 18'h00010, 1, 16'h0000, 0, 16'h0);
    vecs[12] = mk("rd_0x10_kept", 0, 1, 0, 0, 0, 18'h00010, 0, 16'h0000, 1, 16'h1234);
    vecs[13] = mk("rd_oe_off",    0, 1, 1, 0, 0, 18'h00020, 0, 16'h0000, 1, BUS_Z);
    vecs[14] = mk("rd7_again",    0, 1, 0, 0, 0, 18'd7,     0, 16'h0000, 1, 16'hFFAA);

    dut.SRAM_data[7] <= 16'hFFFF;
    dut.SRAM_data[9] <= 16'h0909;
    rc0 = dut.read_count;
    wc0 = dut.write_count;
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i]);
    end
    check16("mem7_lane_write", dut.SRAM_data[7], 16'hFFAA);
    check16("mem9_ce_off", dut.SRAM_data[9], 16'h0909);
    check16("mem10_no_lanes", dut.SRAM_data[18'h00010], 16'h1234);
    check_int("table_write_count", dut.write_count - wc0, 5);
    check_int("table_read_count", dut.read_count - rc0, 8);

    // Burst read on consecutive cycles after a fresh reset.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      dut.SRAM_data[i] <= 16'(i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      apply(mk($sformatf("burst_rd%0d", i), 0, 1, 0, 0, 0, 18'(i), 0, 16'h0,
               1, 16'(i + 1)));
    end
    check_int("burst_read_count", dut.read_count, 4);

    // Write with OE_N also low: write lands, model stays off the bus.
    rc0 = dut.read_count;
    wc0 = dut.write_count;
    apply(mk("contention_wr3", 0, 0, 0, 0, 0, 18'd3, 1, 16'h7777, 1, 16'h7777));
    check16("contention_mem3", dut.SRAM_data[3], 16'h7777);
    apply(mk("contention_bus_z", 0, 0, 0, 1, 1, 18'd3, 0, 16'h0000, 1, BUS_Z));
    check16("contention_mem3_kept", dut.SRAM_data[3], 16'h7777);
    check_int("contention_write_count", dut.write_count - wc0, 2);
    check_int("contention_read_count", dut.read_count - rc0, 0);

    set_idle();
    repeat (2) @(negedge Clock_50);
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_emulator_model.md
Name: sram_emulator_model

Overview:
- Cycle-based simulation model of the 256K x 16 external asynchronous SRAM on the board.
- Sits between the top-level design's SRAM controller pins and the bench.
- Provides byte-lane writes, registered reads, and a bulk clear on reset.
- Exposes its storage array by hierarchical name so the bench can preload images and dump results directly.

Parameters:
- ADDR_WIDTH, 18, word-address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, word width; must be 16, split into high and low byte lanes.

Ports:
- Clock_50  input  1  50 MHz clock; all memory activity on rising edge.
- Resetn  input  1  asynchronous, active-low reset; clears memory and read register.
- SRAM_data_io  inout  DATA_WIDTH  bidirectional data bus.
- SRAM_address  input  ADDR_WIDTH  word address.
- SRAM_UB_N  input  1  active-low high-byte lane enable, bits 15:8.
- SRAM_LB_N  input  1  active-low low-byte lane enable, bits 7:0.
- SRAM_WE_N  input  1  active-low write enable.
- SRAM_CE_N  input  1  active-low chip enable.
- SRAM_OE_N  input  1  active-low output enable.

Behaviour:
- Storage:
  - Unpacked array named exactly SRAM_data, index 0 to 2**ADDR_WIDTH-1, each DATA_WIDTH bits.
  - The bench may read and write it hierarchically at any time.
  - Preloaded contents persist until overwritten by a bus write or reset.
- Reset (Resetn low, async):
  - Every SRAM_data word = 16'h0000.
  - Read register = 16'h0000.
  - Bus released to Z.
  - Access counters (internal integers read_count, write_count) = 0.
  - Holds while low; after release, memory is untouched until accessed.
- Write (rising edge, CE_N=0, WE_N=0):
  - UB_N=0: SRAM_data[addr][15:8] <= SRAM_data_io[15:8].
  - LB_N=0: SRAM_data[addr][7:0] <= SRAM_data_io[7:0].
  - Both lanes disabled: no change, but write_count still increments.
- Read (rising edge, CE_N=0, WE_N=1):
  - Read register <= SRAM_data[addr]; a disabled lane's byte is registered as 8'h00.
  - read_count increments.
- Bus drive:
  - SRAM_data_io = read register whenever Resetn=1, CE_N=0, OE_N=0 and WE_N=1; otherwise Z.
  - Drive is combinational on the current control levels.
- Latency:
  - Address and controls presented before edge k give data on the bus after edge k.
  - The controller samples that data at edge k+1.
  - Back-to-back reads sustain one word per cycle.
- Read-after-write: a write at edge k followed by a read of the same address at edge k+1 returns the new data.
- CE_N=1: no access, read register holds its value, bus Z.
- Address wrap: the address is exactly ADDR_WIDTH bits, so no out-of-range access is possible; upper system address bits are not connected.
- Contention (WE_N=0 and OE_N=0 with CE_N=0):
  - Write takes precedence and the model does not drive the bus.
  - Issue $warning once per occurrence with address and time.
- X/Z checking: X/Z on CE_N, WE_N, or on address while CE_N=0, with Resetn=1 at a rising edge:
  - $error.
  - No memory update that cycle.
  - Read register set to all X.
- Reset mid-operation: an in-flight read or write is discarded; the clear wins.

Test Plan:
- Pulse Resetn low one cycle after hierarchically writing SRAM_data[5]=16'hABCD -> SRAM_data[5]=16'h0000, bus Z.
- Write 16'h1234 to addr 0x00010 with UB_N=LB_N=0, then read addr 0x00010 with OE_N=0 -> bus shows 16'h1234 one edge after the read request.
- Preload addr 7=16'hFFFF; write 16'h00AA with UB_N=1, LB_N=0 -> SRAM_data[7]=16'hFFAA; read with LB_N=1 -> 16'hFF00.
- Burst-read addrs 0..3, preloaded 16'h0001..16'h0004, on consecutive cycles -> bus shows 0001,0002,0003,0004 on consecutive cycles; read_count=4.
- CE_N=1 with WE_N=0 and data 16'h5555 at addr 9 -> SRAM_data[9] unchanged, bus Z.
- WE_N=0 and OE_N=0 together at addr 3 with data 16'h7777 -> SRAM_data[3]=16'h7777, one $warning, model never drives the bus.
